// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests a word at pc, holds it for execute until retire,
// then selects the next pc and traps to the vector on a misaligned target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  next_pc_select,
  input  logic [31:0] pc_plus_imm,
  input  logic [31:0] jalr_target,
  input  logic [31:0] trap_target,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic        misaligned_fetch
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        armed_q;
  logic [31:0] target;
  logic [31:0] trap_aligned;

  // armed_q keeps imem_req low during reset and until the first edge after release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      armed_q <= 1'b1;
    end
  end

  assign trap_aligned = trap_target & 32'hFFFF_FFFC;

  always_comb begin
    target = pc_q + 32'd4;
    case (next_pc_select)
      2'b00:   target = pc_q + 32'd4;
      2'b01:   target = pc_plus_imm;
      2'b10:   target = jalr_target & 32'hFFFF_FFFE;
      default: target = trap_aligned;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_REQ: begin
        if (imem_req && imem_ready) begin
          inst_d  = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (retire) begin
          pc_d    = target;
          inst_d  = NOP_INST;
          state_d = (target[1:0] == 2'b00) ? S_REQ : S_FAULT;
        end
      end
      S_FAULT: begin
        pc_d    = trap_aligned;
        state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem_req         = armed_q && (state_q == S_REQ);
  assign imem_addr        = pc_q;
  assign pc               = pc_q;
  assign inst             = inst_q;
  assign inst_valid       = (state_q == S_HOLD);
  assign misaligned_fetch = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// fetch/retire stream checked against a transaction-level model of the pc flow.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic [1:0]  next_pc_select;
  logic [31:0] pc_plus_imm;
  logic [31:0] jalr_target;
  logic [31:0] trap_target;
  logic        retire;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic        misaligned_fetch;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: address of the pending fetch and the word/pc being held.
  logic [31:0] cur_addr;
  logic [31:0] model_pc;
  logic [31:0] model_inst;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clock(clock), .reset(reset), .next_pc_select(next_pc_select),
    .pc_plus_imm(pc_plus_imm), .jalr_target(jalr_target), .trap_target(trap_target),
    .retire(retire), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst(inst),
    .inst_valid(inst_valid), .pc(pc), .misaligned_fetch(misaligned_fetch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] model_next(input logic [1:0] sel, input logic [31:0] cur_pc,
                                             input logic [31:0] pii, input logic [31:0] jt,
                                             input logic [31:0] tt);
    case (sel)
      2'd0:    return cur_pc + 32'd4;
      2'd1:    return pii;
      2'd2:    return jt - (jt % 2);
      default: return tt - (tt % 4);
    endcase
  endfunction

  // One memory transaction at exp_a with `waits` stall cycles; retire noise is ignored in REQ.
  task automatic fetch(input int waits, input logic [31:0] data, input logic [31:0] exp_a);
    for (int i = 0; i <= waits; i++) begin
      tests_run++;
      if ({imem_req, imem_addr, inst_valid, misaligned_fetch} !== {1'b1, exp_a, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL fetch_req cyc%0d: req=%b addr=%h valid=%b mis=%b, required req=1 addr=%h valid=0 mis=0",
                 i, imem_req, imem_addr, inst_valid, misaligned_fetch, exp_a);
      end
      imem_ready     = (i == waits);
      imem_rdata     = (i == waits) ? data : $urandom;
      retire         = 1'($urandom_range(0, 1));
      next_pc_select = 2'($urandom);
      pc_plus_imm    = $urandom;
      tick();
    end
    imem_ready = 1'b0;
    retire     = 1'b0;
    imem_rdata = $urandom;
    tests_run++;
    if ({inst_valid, inst, pc, imem_req, misaligned_fetch} !== {1'b1, data, exp_a, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL fetch_capture: valid=%b inst=%h pc=%h req=%b mis=%b, required valid=1 inst=%h pc=%h req=0 mis=0",
               inst_valid, inst, pc, imem_req, misaligned_fetch, data, exp_a);
    end
    model_pc   = exp_a;
    model_inst = data;
  endtask

  // Hold for `hold` cycles, then retire with the given selector; updates cur_addr.
  task automatic retire_with(input logic [1:0] sel, input logic [31:0] pii, input logic [31:0] jt,
                             input logic [31:0] tt, input int hold);
    logic [31:0] tgt;
    for (int i = 0; i < hold; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      tick();
      tests_run++;
      if ({inst_valid, inst, pc, imem_req} !== {1'b1, model_inst, model_pc, 1'b0}) begin
        tests_failed++;
        $display("FAIL hold_wait cyc%0d: valid=%b inst=%h pc=%h req=%b, required valid=1 inst=%h pc=%h req=0",
                 i, inst_valid, inst, pc, imem_req, model_inst, model_pc);
      end
    end
    imem_ready     = 1'($urandom_range(0, 1));
    next_pc_select = sel;
    pc_plus_imm    = pii;
    jalr_target    = jt;
    trap_target    = tt;
    retire         = 1'b1;
    tick();
    retire     = 1'b0;
    imem_ready = 1'b0;
    tgt = model_next(sel, model_pc, pii, jt, tt);
    if (tgt % 4 == 0) begin
      tests_run++;
      if ({imem_req, imem_addr, inst_valid, inst, misaligned_fetch} !== {1'b1, tgt, 1'b0, NOP_INST, 1'b0}) begin
        tests_failed++;
        $display("FAIL retire_next sel=%0d: req=%b addr=%h valid=%b inst=%h mis=%b, required req=1 addr=%h valid=0 inst=%h mis=0",
                 sel, imem_req, imem_addr, inst_valid, inst, misaligned_fetch, tgt, NOP_INST);
      end
      cur_addr = tgt;
    end else begin
      tests_run++;
      if ({misaligned_fetch, pc, inst_valid, imem_req} !== {1'b1, tgt, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL fault_entry sel=%0d: mis=%b pc=%h valid=%b req=%b, required mis=1 pc=%h valid=0 req=0",
                 sel, misaligned_fetch, pc, inst_valid, imem_req, tgt);
      end
      retire     = 1'($urandom_range(0, 1));
      imem_ready = 1'($urandom_range(0, 1));
      tick();
      retire     = 1'b0;
      imem_ready = 1'b0;
      cur_addr   = tt - (tt % 4);
      tests_run++;
      if ({misaligned_fetch, imem_req, imem_addr, inst_valid} !== {1'b0, 1'b1, cur_addr, 1'b0}) begin
        tests_failed++;
        $display("FAIL fault_exit: mis=%b req=%b addr=%h valid=%b, required mis=0 req=1 addr=%h valid=0",
                 misaligned_fetch, imem_req, imem_addr, inst_valid, cur_addr);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; retire = 1'b0; next_pc_select = 2'd0;
    pc_plus_imm = '0; jalr_target = '0; trap_target = '0;
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    tests_run++;
    if ({imem_req, pc, inst, inst_valid, misaligned_fetch} !== {1'b0, RESET_PC, NOP_INST, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: req=%b pc=%h inst=%h valid=%b mis=%b, required req=0 pc=%h inst=%h valid=0 mis=0",
               imem_req, pc, inst, inst_valid, misaligned_fetch, RESET_PC, NOP_INST);
    end
    reset = 1'b0;
    imem_ready = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_req: req=%b before first edge, required 0", imem_req);
    end
    tick();
    cur_addr = RESET_PC;
  endtask

  task automatic test_basic();
    fetch(0, 32'h0000_0093, cur_addr);
    retire_with(2'd0, $urandom, $urandom, 32'h0040_1000, 1);
  endtask

  task automatic test_wait_and_jalr();
    fetch(3, $urandom, cur_addr);
    retire_with(2'd2, $urandom, 32'h0040_0101, 32'h0040_1000, 2);
  endtask

  task automatic test_fault();
    fetch(1, $urandom, cur_addr);
    retire_with(2'd1, 32'h0040_0102, $urandom, 32'h0040_1003, 0);
  endtask

  task automatic test_wrap();
    fetch(0, $urandom, cur_addr);
    retire_with(2'd1, 32'hFFFF_FFFC, $urandom, 32'h0040_1000, 1);
    fetch(2, $urandom, cur_addr);
    retire_with(2'd0, $urandom, $urandom, 32'h0040_1000, 0);
    fetch(0, $urandom, cur_addr);
    retire_with(2'd3, $urandom, $urandom, 32'h0040_1002, 0);
  endtask

  task automatic test_reset_midfetch();
    tick();
    tests_run++;
    if ({imem_req, imem_addr} !== {1'b1, cur_addr}) begin
      tests_failed++;
      $display("FAIL midfetch_pre: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, cur_addr);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({imem_req, pc, inst, inst_valid, misaligned_fetch} !== {1'b0, RESET_PC, NOP_INST, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midfetch_async_reset: req=%b pc=%h inst=%h valid=%b mis=%b, required req=0 pc=%h inst=%h valid=0 mis=0",
               imem_req, pc, inst, inst_valid, misaligned_fetch, RESET_PC, NOP_INST);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    tick(); tick();
    tests_run++;
    if ({imem_req, inst, inst_valid} !== {1'b0, NOP_INST, 1'b0}) begin
      tests_failed++;
      $display("FAIL midfetch_ready_ignored: req=%b inst=%h valid=%b, required req=0 inst=%h valid=0",
               imem_req, inst, inst_valid, NOP_INST);
    end
    reset = 1'b0;
    imem_ready = 1'b0;
    tick();
    cur_addr = RESET_PC;
    fetch(1, $urandom, cur_addr);
    retire_with(2'd0, $urandom, $urandom, 32'h0040_1000, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sel;
      logic [31:0] pii, jt, tt;
      sel = 2'($urandom);
      pii = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      jt  = $urandom;
      tt  = $urandom;
      fetch($urandom_range(0, 4), $urandom, cur_addr);
      retire_with(sel, pii, jt, tt, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_and_jalr();
    test_fault();
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
